// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: round-robin timed watering cycles on one shared pump with dry lockout
module irrigation_scheduler #(
    parameter int PRIME_TICKS = 2,
    parameter int RUN_TICKS   = 10,
    parameter int REST_TICKS  = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       sprinkler_req_i,
    input  logic       drip_req_i,
    input  logic       specific_req_i,
    input  logic [1:0] water_box_i,
    output logic [2:0] valve_o,
    output logic       pump_on_o,
    output logic       busy_o,
    output logic       fault_o,
    output logic [7:0] cycles_done_o
);

    typedef enum logic [2:0] {IDLE, PRIME, RUN, REST, DRY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       grant_q, grant_d, req;
    logic [1:0]       last_q, last_d, c1, c2, pick;
    logic [7:0]       cycles_q, cycles_d;
    logic             dry, prime_end, run_end, rest_end, req_lost;

    assign req       = {specific_req_i, drip_req_i, sprinkler_req_i};
    assign dry       = ~water_box_i[1];
    assign prime_end = tick_i && (cnt_q == CNT_W'(PRIME_TICKS - 1));
    assign run_end   = tick_i && (cnt_q == CNT_W'(RUN_TICKS - 1));
    assign rest_end  = tick_i && (cnt_q == CNT_W'(REST_TICKS - 1));
    assign req_lost  = ~|(req & grant_q);

    // Round-robin search upward from the channel after the last grant; falls back to last_q
    assign c1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    assign c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    assign pick = req[c1] ? c1 : req[c2] ? c2 : last_q;

    // Next-state, grant latch, phase counter and completed-cycle counter
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (dry) begin
                    state_d = DRY;
                end else if (|req) begin
                    state_d = PRIME;
                    grant_d = 3'b001 << pick;
                    last_d  = pick;
                end
            end
            PRIME:   state_d = dry ? DRY : prime_end ? RUN : PRIME;
            RUN:     state_d = dry ? DRY : (req_lost || run_end) ? REST : RUN;
            REST:    state_d = rest_end ? IDLE : REST;
            DRY:     state_d = dry ? DRY : IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d    = (state_d != state_q) ? '0 : tick_i ? cnt_q + CNT_W'(1) : cnt_q;
        cycles_d = (state_q == RUN && state_d != RUN && cycles_q != 8'hFF) ? cycles_q + 8'd1 : cycles_q;
    end

    // State and datapath registers; last grant resets to 2 so channel 0 wins first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= 3'b000;
            last_q   <= 2'd2;
            cycles_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cycles_q <= cycles_d;
        end
    end

    assign valve_o       = (state_q == PRIME || state_q == RUN) ? grant_q : 3'b000;
    assign pump_on_o     = (state_q == RUN);
    assign busy_o        = (state_q == PRIME || state_q == RUN || state_q == REST);
    assign fault_o       = (state_q == DRY);
    assign cycles_done_o = cycles_q;

endmodule
